// File: rtl/reg_exe_pipe_latch.sv
// rtl/reg_exe_pipe_latch.sv - register-read to execute pipeline latch with 2-entry skid buffer
// Optional LATCH_STATS_EN adds saturating stall_count / flush_count outputs.
module reg_exe_pipe_latch #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               reg_valid,
  output logic               reg_ready,
  input  logic [DATA_W-1:0]  reg_int_data_a,
  input  logic [DATA_W-1:0]  reg_int_data_b,
  input  logic               reg_int_write_enable,
  input  logic [ADDR_W-1:0]  reg_write_addr,
  input  logic [INSTR_W-1:0] reg_instruction,
  output logic               exe_valid,
  input  logic               exe_ready,
  output logic [DATA_W-1:0]  exe_int_data_a,
  output logic [DATA_W-1:0]  exe_int_data_b,
  output logic               exe_int_write_enable,
  output logic [ADDR_W-1:0]  exe_write_addr,
  output logic [INSTR_W-1:0] exe_instruction
`ifdef LATCH_STATS_EN
  ,
  output logic [31:0]        stall_count,
  output logic [15:0]        flush_count
`endif
);

  localparam int PW = 2 * DATA_W + 1 + ADDR_W + INSTR_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   in_pl;
  logic [PW-1:0]   main_pl;
  logic [PW-1:0]   skid_pl;
  logic            main_we;
  logic            in_xfer;
  logic            out_xfer;
  logic            load_main;
  logic            load_skid;
  logic            main_from_skid;

  assign in_pl = {reg_int_data_a, reg_int_data_b, reg_int_write_enable,
                  reg_write_addr, reg_instruction};

  assign exe_valid = (state != EMPTY);
  assign {exe_int_data_a, exe_int_data_b, main_we, exe_write_addr, exe_instruction} = main_pl;
  assign exe_int_write_enable = main_we & exe_valid;

  always_comb begin
    in_xfer        = reg_valid & reg_ready;
    out_xfer       = exe_valid & exe_ready;
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // reg_ready is low here, so the skid drains without a fresh capture
        if (out_xfer) begin
          main_from_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      reg_ready <= 1'b0;
      main_pl   <= '0;
      skid_pl   <= '0;
    end else begin
      state     <= state_next;
      reg_ready <= (state_next != TWO);
      if (load_main)
        main_pl <= in_pl;
      else if (main_from_skid)
        main_pl <= skid_pl;
      if (load_skid)
        skid_pl <= in_pl;
    end
  end

`ifdef LATCH_STATS_EN
  // A flush counts only when it actually discards something, including a same-cycle input.
  logic flush_hit;
  assign flush_hit = flush & ((state != EMPTY) | in_xfer);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (exe_valid && !exe_ready && !(&stall_count))
        stall_count <= stall_count + 32'd1;
      if (flush_hit && !(&flush_count))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_exe_pipe_latch.sv
// tb/tb_reg_exe_pipe_latch.sv - scoreboard bench for reg_exe_pipe_latch
// Define LATCH_STATS_EN to also exercise the statistics counters.
module tb_reg_exe_pipe_latch;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] instr;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        reg_valid;
  logic        reg_ready;
  logic [63:0] reg_int_data_a;
  logic [63:0] reg_int_data_b;
  logic        reg_int_write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_instruction;
  logic        exe_valid;
  logic        exe_ready;
  logic [63:0] exe_int_data_a;
  logic [63:0] exe_int_data_b;
  logic        exe_int_write_enable;
  logic [4:0]  exe_write_addr;
  logic [31:0] exe_instruction;
`ifdef LATCH_STATS_EN
  logic [31:0] stall_count;
  logic [15:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;
  entry_t q[$];

  reg_exe_pipe_latch dut (
    .clock(clock), .reset(reset), .flush(flush),
    .reg_valid(reg_valid), .reg_ready(reg_ready),
    .reg_int_data_a(reg_int_data_a), .reg_int_data_b(reg_int_data_b),
    .reg_int_write_enable(reg_int_write_enable), .reg_write_addr(reg_write_addr),
    .reg_instruction(reg_instruction),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_int_data_a(exe_int_data_a), .exe_int_data_b(exe_int_data_b),
    .exe_int_write_enable(exe_int_write_enable), .exe_write_addr(exe_write_addr),
    .exe_instruction(exe_instruction)
`ifdef LATCH_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic entry_t mk(int i);
    entry_t e;
    e.a     = 64'(i);
    e.b     = 64'hA5A5_0000_0000_0000 ^ 64'(i * 3);
    e.we    = i[0];
    e.addr  = i[4:0];
    e.instr = 32'h0000_0013 + 32'(i);
    return e;
  endfunction

  function automatic entry_t cur_out();
    entry_t e;
    e = {exe_int_data_a, exe_int_data_b, exe_int_write_enable, exe_write_addr, exe_instruction};
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_e(string tag, entry_t obs, entry_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(entry_t e, logic v);
    reg_valid            = v;
    reg_int_data_a       = e.a;
    reg_int_data_b       = e.b;
    reg_int_write_enable = e.we;
    reg_write_addr       = e.addr;
    reg_instruction      = e.instr;
  endtask

  // Scoreboard bookkeeping for the upcoming edge, then advance to the next negedge.
  task automatic step();
    entry_t e;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (exe_valid && exe_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(exe_instruction), 64'hDEAD);
        end else begin
          e = q.pop_front();
          check_e("payload", cur_out(), e);
        end
      end
      if (reg_valid && reg_ready)
        q.push_back({reg_int_data_a, reg_int_data_b, reg_int_write_enable,
                     reg_write_addr, reg_instruction});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    entry_t e;
    logic acc;
    reset = 1'b1;
    flush = 1'b0;
    exe_ready = 1'b0;
    drive(mk(0), 1'b0);
    @(negedge clock);
    step();
    step();
    check("rst_ready_low", 64'(reg_ready), 64'd0);
    reset = 1'b0;
    step();
    check("rst_ready", 64'(reg_ready), 64'd1);
    check("rst_valid", 64'(exe_valid), 64'd0);
    check("rst_we", 64'(exe_int_write_enable), 64'd0);
    check("rst_data_a", exe_int_data_a, 64'd0);
    check("rst_data_b", exe_int_data_b, 64'd0);
    check("rst_addr", 64'(exe_write_addr), 64'd0);
    check("rst_instr", 64'(exe_instruction), 64'd0);

    // Full-rate stream: one-cycle latency, no bubbles
    exe_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(mk(i), 1'b1);
      step();
      check("stream_valid", 64'(exe_valid), 64'd1);
      check("stream_instr", 64'(exe_instruction), 64'h13 + 64'(i));
    end
    drive(mk(0), 1'b0);
    step();
    check("stream_drained", 64'(q.size()), 64'd0);
    check("stream_idle", 64'(exe_valid), 64'd0);

    // Back-pressure: two accepted, third blocked, payload stable
    exe_ready = 1'b0;
    drive(mk(20), 1'b1);
    step();
    drive(mk(21), 1'b1);
    step();
    check("bp_ready_low", 64'(reg_ready), 64'd0);
    drive(mk(22), 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      check_e("bp_stable", cur_out(), mk(20));
      check("bp_ready_held", 64'(reg_ready), 64'd0);
    end
    exe_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = reg_valid && reg_ready;
      step();
    end
    check("bp_third_accepted", 64'(acc), 64'd1);
    drive(mk(0), 1'b0);
    for (int k = 0; k < 8 && q.size() > 0; k++) step();
    check("bp_drained", 64'(q.size()), 64'd0);
    check("bp_idle", 64'(exe_valid), 64'd0);

    // Flush in TWO with a same-cycle input
    exe_ready = 1'b0;
    e = mk(30); e.we = 1'b1; drive(e, 1'b1);
    step();
    e = mk(31); e.we = 1'b1; drive(e, 1'b1);
    step();
    e = mk(32); e.we = 1'b1; drive(e, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(mk(0), 1'b0);
    check("flush_valid", 64'(exe_valid), 64'd0);
    check("flush_we", 64'(exe_int_write_enable), 64'd0);
    check("flush_ready", 64'(reg_ready), 64'd1);
    exe_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_gone", 64'(exe_valid), 64'd0);
    end

    // Reset while holding one entry
    exe_ready = 1'b0;
    e = mk(40); e.we = 1'b1; e.addr = 5'd7; drive(e, 1'b1);
    step();
    drive(mk(0), 1'b0);
    check("one_we", 64'(exe_int_write_enable), 64'd1);
    check("one_addr", 64'(exe_write_addr), 64'd7);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(exe_valid), 64'd0);
    check("mid_rst_addr", 64'(exe_write_addr), 64'd0);
    check("mid_rst_we", 64'(exe_int_write_enable), 64'd0);
    check("mid_rst_data_a", exe_int_data_a, 64'd0);
    reset = 1'b0;
    step();
    check("mid_rst_ready", 64'(reg_ready), 64'd1);

    // Random valid/ready traffic, scoreboard checks order and content
    for (int k = 0; k < 60; k++) begin
      drive(mk(100 + k), 1'($urandom_range(0, 1)));
      exe_ready = 1'($urandom_range(0, 1));
      step();
      if (!exe_valid) check("rand_we_gated", 64'(exe_int_write_enable), 64'd0);
    end
    drive(mk(0), 1'b0);
    exe_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    check("rand_drained", 64'(q.size()), 64'd0);

`ifdef LATCH_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("stat_rst_stall", 64'(stall_count), 64'd0);
    check("stat_rst_flush", 64'(flush_count), 64'd0);
    exe_ready = 1'b0;
    drive(mk(50), 1'b1);
    step();
    drive(mk(0), 1'b0);
    for (int k = 0; k < 5; k++) step();
    exe_ready = 1'b1;
    step();
    check("stall_count", 64'(stall_count), 64'd5);
    flush = 1'b1;
    step();
    drive(mk(51), 1'b1);
    step();
    step();
    flush = 1'b0;
    drive(mk(0), 1'b0);
    check("flush_count", 64'(flush_count), 64'd2);
    check("stall_after_flush", 64'(stall_count), 64'd5);
    flush = 1'b1;
    drive(mk(52), 1'b1);
    for (int k = 0; k < 65540; k++) step();
    flush = 1'b0;
    drive(mk(0), 1'b0);
    step();
    check("flush_sat", 64'(flush_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
